rotate_left_seq: RTL and testbench
==================================

Name: rotate_left_seq

Overview:
- Sequential left rotator: the inverse-direction companion to the team's combinational right rotator.
- Accepts a word and a rotate amount under a start/done handshake, then rotates left one bit position per clock.
- Presents the registered result with a one-cycle done pulse.
- Rotating a right-rotated word left by the same amount restores the original word. This unit is used to undo right rotations in the datapath and to cross-check the right rotator in system benches.

Parameters:
- WIDTH, 4, data word width in bits; must be a power of two and >= 2.
- AW, $clog2(WIDTH), width of the rotate-amount input. Derived; not overridden independently.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand word; captured on an accepted start.
- Rol  input  AW  left-rotate amount, 0..WIDTH-1; captured on an accepted start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; f is valid while done is high.
- f  output  WIDTH  registered result, held until the next completion or reset.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, f=0, shift register=0, count=0. Reset has priority over all other inputs, including mid-operation: an in-flight operation is discarded and no done is produced.
- States: IDLE, ROT, DONE. Outputs: busy=1 in ROT and DONE; done=1 only in DONE. Both are decoded from registered state, so they are glitch-free.
- IDLE, start=0: stay in IDLE; f holds.
- IDLE, start=1: shift register <= a, count <= Rol.
  - Rol==0: f <= a, next state DONE.
  - Rol!=0: next state ROT.
- ROT: each edge, shift register <= {sr[WIDTH-2:0], sr[WIDTH-1]}, and count <= count-1.
  - On the edge where count==1, f <= the rotated value and next state is DONE.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- Latency: start accepted at edge k with Rol=N gives done high for the single cycle following edge k+N (N=0: the cycle after edge k).
- Completion: f == a rotated left by N. Equivalently, f[(i+N) mod WIDTH] = a[i].
- Inputs after acceptance: a and Rol are ignored while busy. Changes after the start edge do not affect the result.
- start while busy (ROT or DONE): ignored, not queued. A new start is accepted at the earliest in the cycle after DONE, i.e. in IDLE.
- Back-to-back throughput: one operation per N+2 cycles.
- f changes only on the completion edge (entry to DONE) or on reset, and is stable at all other times.
- Arithmetic: count is AW bits and never underflows, because ROT is entered only with count>=1. No arithmetic on data; pure bit permutation.

Test Plan:
- WIDTH=4, reset, then start with a=0011, Rol=1 -> done pulses one cycle after the start edge, f=0110, busy high for exactly 2 cycles.
- a=0011, Rol=3 -> done 3 edges after the start edge, f=1001. Repeat with Rol=2 -> f=1100, then Rol=0 -> f=0011 with done in the cycle immediately after the start edge.
- Round trip against the right rotator: for all 16 values of a and all 4 amounts, feed the right-rotated word with the same amount -> f equals the original a every time, with exactly one done per start.
- start held high continuously, a=0001, Rol=3 -> operations complete every 5 cycles. f=1000 each time. a/Rol changes during busy have no effect.
- Assert reset during ROT (a=0101, Rol=3, after 1 rotation) -> next cycle busy=0, done=0, f=0000. No done pulse appears afterward.
- Assert start in the DONE cycle -> ignored. f holds the previous result until a later start in IDLE completes.

Source files
------------

// File: rtl/rotate_left_seq_if.sv
// Handshake bundle for the sequential left rotator: request side drives start/a/Rol,
// rotator side returns busy/done and the registered result f.
interface rotate_left_seq_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AW    = $clog2(WIDTH)
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [AW-1:0]    Rol;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;

    modport master (
        output start,
        output a,
        output Rol,
        input  busy,
        input  done,
        input  f
    );

    modport slave (
        input  start,
        input  a,
        input  Rol,
        output busy,
        output done,
        output f
    );
endinterface

// File: rtl/rotate_left_seq.sv
// Sequential left rotator: captures a word and amount on start, rotates one bit per clock,
// then presents the result with a one-cycle done pulse. Undoes a right rotation by the same amount.
module rotate_left_seq #(
    parameter int unsigned WIDTH = 4
) (
    input logic              clk,
    input logic              reset,
    rotate_left_seq_if.slave bus
);
    localparam int unsigned AW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRot, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] f_reg;
    logic [AW-1:0]    count;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] sr_rot;

    assign sr_rot = {sr[WIDTH-2:0], sr[WIDTH-1]};

    // busy/done are registered alongside the state so they track it exactly without decode glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            sr       <= '0;
            count    <= '0;
            f_reg    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus.start) begin
                        sr       <= bus.a;
                        count    <= bus.Rol;
                        busy_reg <= 1'b1;
                        if (bus.Rol == '0) begin
                            f_reg    <= bus.a;
                            done_reg <= 1'b1;
                            state    <= StDone;
                        end else begin
                            state <= StRot;
                        end
                    end
                end
                StRot: begin
                    sr    <= sr_rot;
                    count <= count - 1'b1;
                    // ROT is only entered with count >= 1, so this is the last rotation step.
                    if (count == AW'(1)) begin
                        f_reg    <= sr_rot;
                        done_reg <= 1'b1;
                        state    <= StDone;
                    end
                end
                StDone: begin
                    busy_reg <= 1'b0;
                    state    <= StIdle;
                end
                default: begin
                    busy_reg <= 1'b0;
                    state    <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.f    = f_reg;
endmodule

// File: tb/tb_rotate_left_seq.sv
// Self-checking bench for rotate_left_seq: directed and random operations against an
// index-based rotation model, plus handshake, throughput and reset corner cases.
module tb_rotate_left_seq;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned AW    = $clog2(WIDTH);

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [WIDTH-1:0] last_f;

    rotate_left_seq_if #(.WIDTH(WIDTH)) bus ();

    rotate_left_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int n);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[(i + n) % WIDTH] = v[i];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input int n);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[(i + n) % WIDTH];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE, scramble inputs while busy, and check result/latency/handshake.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input int n,
                          input logic [WIDTH-1:0] exp);
        int lat;
        int ndone;
        int busy_cycles;
        logic stable;
        logic [WIDTH-1:0] res;
        lat = -1; ndone = 0; busy_cycles = 0; stable = 1'b1; res = 'x;
        bus.start = 1'b1;
        bus.a     = av;
        bus.Rol   = AW'(n);
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < WIDTH + 4; c++) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                if (ndone == 0) begin
                    lat = c;
                    res = bus.f;
                end
                ndone++;
            end else if (ndone == 0 && bus.f !== last_f) begin
                stable = 1'b0;
            end
            bus.a   = WIDTH'($urandom);
            bus.Rol = AW'($urandom);
            if (!bus.busy) break;
            tick();
        end
        check({tag, ".f"}, 32'(res), 32'(exp));
        check({tag, ".latency"}, 32'(lat), 32'(n));
        check({tag, ".ndone"}, 32'(ndone), 32'd1);
        check({tag, ".busy_cycles"}, 32'(busy_cycles), 32'(n + 1));
        check({tag, ".f_stable"}, 32'(stable), 32'd1);
        last_f = exp;
    endtask

    initial begin
        int ndone;
        int last_done;
        int waited;
        total = 0;
        bad = 0;
        last_f = '0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.Rol = '0;

        tick();
        tick();
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.f", 32'(bus.f), 32'd0);
        reset = 1'b0;
        tick();

        run_op("dir_r1", 4'b0011, 1, 4'b0110);
        run_op("dir_r3", 4'b0011, 3, 4'b1001);
        run_op("dir_r2", 4'b0011, 2, 4'b1100);
        run_op("dir_r0", 4'b0011, 0, 4'b0011);

        for (int av = 0; av < 16; av++) begin
            for (int n = 0; n < 4; n++) begin
                run_op($sformatf("roundtrip_a%0d_n%0d", av, n), rotr(WIDTH'(av), n), n, WIDTH'(av));
            end
        end

        for (int k = 0; k < 20; k++) begin
            logic [WIDTH-1:0] av;
            int n;
            av = WIDTH'($urandom);
            n  = int'($urandom_range(WIDTH - 1, 0));
            run_op($sformatf("rand%0d", k), av, n, rotl(av, n));
        end

        // Continuous start: accepts at edges 1,6,11,16,21 -> dones after edges 4,9,14,19,24.
        bus.start = 1'b1;
        bus.a = 4'b0001;
        bus.Rol = AW'(3);
        ndone = 0;
        last_done = -1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (bus.done) begin
                check("cont.f", 32'(bus.f), 32'h8);
                if (last_done >= 0) check("cont.period", 32'(c - last_done), 32'd5);
                ndone++;
                last_done = c;
            end
            if (bus.busy) begin
                bus.a = WIDTH'($urandom);
                bus.Rol = AW'($urandom);
            end else begin
                bus.a = 4'b0001;
                bus.Rol = AW'(3);
            end
        end
        bus.start = 1'b0;
        check("cont.ndone", 32'(ndone), 32'd5);
        check("cont.idle", 32'(bus.busy), 32'd0);
        last_f = 4'b1000;

        // Reset after one rotation discards the operation.
        bus.start = 1'b1;
        bus.a = 4'b0101;
        bus.Rol = AW'(3);
        tick();
        bus.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid.busy", 32'(bus.busy), 32'd0);
        check("rst_mid.done", 32'(bus.done), 32'd0);
        check("rst_mid.f", 32'(bus.f), 32'd0);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.done) ndone++;
        end
        check("rst_mid.no_done", 32'(ndone), 32'd0);
        last_f = '0;

        // Start raised during the DONE cycle must be ignored.
        bus.start = 1'b1;
        bus.a = 4'b0011;
        bus.Rol = AW'(2);
        tick();
        bus.start = 1'b0;
        waited = 0;
        while (!bus.done && waited < 10) begin
            tick();
            waited++;
        end
        check("done_start.reached", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        bus.a = 4'b0101;
        bus.Rol = AW'(1);
        tick();
        bus.start = 1'b0;
        check("done_start.busy", 32'(bus.busy), 32'd0);
        check("done_start.f", 32'(bus.f), 32'hC);
        tick();
        tick();
        tick();
        check("done_start.busy_later", 32'(bus.busy), 32'd0);
        check("done_start.f_held", 32'(bus.f), 32'hC);
        last_f = 4'b1100;
        run_op("after_done_start", 4'b0101, 1, 4'b1010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
